// File: rtl/lb_uart_tx_ctrl_param_if.sv
// Control/strobe bundle between the UART Tx controller and its host/datapath.
interface lb_uart_tx_ctrl_param_if #(
    parameter int PRESCALE_W = 20
);
    logic                  cs;
    logic                  start;
    logic [4:0]            data_bits;
    logic                  parity_en;
    logic                  stop2;
    logic                  break_req;
    logic [PRESCALE_W-1:0] baud_prescale;
    logic                  load;
    logic                  shift;
    logic                  done;
    logic                  busy;
    logic [1:0]            tx_sel;

    modport master (
        output cs, start, data_bits, parity_en, stop2, break_req, baud_prescale,
        input  load, shift, done, busy, tx_sel
    );

    modport slave (
        input  cs, start, data_bits, parity_en, stop2, break_req, baud_prescale,
        output load, shift, done, busy, tx_sel
    );
endinterface

// File: rtl/lb_uart_tx_ctrl_param.sv
// UART transmit control: baud prescaler, oversample and bit counters, frame FSM
// and line-select/strobe generation for the external Tx shift/parity datapath.
module lb_uart_tx_ctrl_param #(
    parameter int PRESCALE_W    = 20,
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    lb_uart_tx_ctrl_param_if.slave  bus
);
    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [4:0]      DB_MIN  = 5'd5;
    localparam logic [4:0]      DB_MAX  = 5'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    typedef enum logic [1:0] {
        SEL_MARK,
        SEL_SPACE,
        SEL_DATA,
        SEL_PARITY
    } sel_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [OS_W-1:0]       ocnt_q, ocnt_d;
    logic [4:0]            bcnt_q, bcnt_d;
    logic [4:0]            dbits_q;
    logic                  par_q, stop2_q;
    logic                  load_pend_q, load_pend_d;
    logic                  cfg_we;
    logic [4:0]            dbits_clamped;
    logic                  tick, bit_end, run;
    sel_t                  sel;

    assign dbits_clamped = (bus.data_bits < DB_MIN) ? DB_MIN :
                           (bus.data_bits > DB_MAX) ? DB_MAX : bus.data_bits;

    // The prescaler restarts at baud_prescale on acceptance, so the last cycle
    // of each prescale period is the tick and bit periods end on a tick.
    assign tick    = (pcnt_q == '0);
    assign bit_end = tick && (ocnt_q == OS_LAST);
    assign run     = bus.cs && (state_q == S_START || state_q == S_DATA ||
                                state_q == S_PARITY || state_q == S_STOP);

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        ocnt_d      = ocnt_q;
        bcnt_d      = bcnt_q;
        load_pend_d = load_pend_q;
        cfg_we      = 1'b0;
        bus.load    = 1'b0;
        bus.shift   = 1'b0;
        bus.done    = 1'b0;
        bus.busy    = (state_q != S_IDLE);
        sel         = SEL_MARK;

        if (run) begin
            if (tick) begin
                pcnt_d = bus.baud_prescale;
                ocnt_d = bit_end ? '0 : ocnt_q + OS_W'(1);
            end else begin
                pcnt_d = pcnt_q - PRESCALE_W'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.cs) begin
                    if (bus.break_req) begin
                        state_d = S_BREAK;
                    end else if (bus.start) begin
                        state_d     = S_START;
                        cfg_we      = 1'b1;
                        pcnt_d      = bus.baud_prescale;
                        ocnt_d      = '0;
                        bcnt_d      = '0;
                        load_pend_d = 1'b1;
                    end
                end
            end
            S_START: begin
                sel = SEL_SPACE;
                // load is held pending across cs=0 so it fires exactly once
                if (bus.cs) begin
                    bus.load    = load_pend_q;
                    load_pend_d = 1'b0;
                    if (bit_end) state_d = S_DATA;
                end
            end
            S_DATA: begin
                sel = SEL_DATA;
                if (bus.cs && bit_end) begin
                    bus.shift = 1'b1;
                    if (bcnt_q == dbits_q - 5'd1) begin
                        bcnt_d  = '0;
                        state_d = par_q ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                sel = SEL_PARITY;
                if (bus.cs && bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                sel = SEL_MARK;
                if (bus.cs && bit_end) begin
                    if (stop2_q && bcnt_q == '0) begin
                        bcnt_d = 5'd1;
                    end else begin
                        bus.done = 1'b1;
                        bcnt_d   = '0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                sel = SEL_SPACE;
                if (bus.cs && !bus.break_req) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus.tx_sel = sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pcnt_q      <= '0;
            ocnt_q      <= '0;
            bcnt_q      <= '0;
            load_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            ocnt_q      <= ocnt_d;
            bcnt_q      <= bcnt_d;
            load_pend_q <= load_pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbits_q <= DB_MIN;
            par_q   <= 1'b0;
            stop2_q <= 1'b0;
        end else if (cfg_we) begin
            dbits_q <= dbits_clamped;
            par_q   <= bus.parity_en;
            stop2_q <= bus.stop2;
        end
    end
endmodule

// File: tb/tb_lb_uart_tx_ctrl_param.sv
// Directed bench for lb_uart_tx_ctrl_param: frame timing, strobes, line select,
// clamping, cs gating, break mode and mid-frame reset.
module tb_lb_uart_tx_ctrl_param;
    localparam int LOG_N = 8192;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    lb_uart_tx_ctrl_param_if #(.PRESCALE_W(20)) bus ();

    lb_uart_tx_ctrl_param #(
        .PRESCALE_W   (20),
        .OVERSAMPLE   (16),
        .MAX_DATA_BITS(9)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    int         load_cnt, shift_cnt, done_cnt, overlap;
    int         last_load, last_done;
    int         shift_q[$];
    logic [1:0] sel_log [LOG_N];
    logic       busy_log[LOG_N];
    int         exp_sel [11] = '{1, 2, 2, 2, 2, 2, 2, 2, 3, 0, 0};
    int         s, l, bad;

    initial begin
        load_cnt = 0; shift_cnt = 0; done_cnt = 0; overlap = 0;
        last_load = -1; last_done = -1;
    end

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            sel_log[cyc]  = bus.tx_sel;
            busy_log[cyc] = bus.busy;
        end
        if (bus.load === 1'b1)  begin load_cnt++;  last_load = cyc; end
        if (bus.shift === 1'b1) begin shift_cnt++; shift_q.push_back(cyc); end
        if (bus.done === 1'b1)  begin done_cnt++;  last_done = cyc; end
        if ((int'(bus.load === 1'b1) + int'(bus.shift === 1'b1) + int'(bus.done === 1'b1)) > 1)
            overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic clear_stats();
        load_cnt = 0; shift_cnt = 0; done_cnt = 0;
        last_load = -1; last_done = -1;
        shift_q.delete();
    endtask

    task automatic launch(input int db, input bit pe, input bit s2, input int pres);
        bus.data_bits     = 5'(db);
        bus.parity_en     = pe;
        bus.stop2         = s2;
        bus.baud_prescale = 20'(pres);
        bus.start         = 1'b1;
        s = cyc;
        l = cyc + 1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int n0 = done_cnt;
        int k  = 0;
        while (done_cnt == n0 && k < budget) begin
            step();
            if (toggle) bus.cs = ~bus.cs;
            k++;
        end
        bus.cs = 1'b1;
        chk("done_seen", done_cnt - n0, 1);
        step();
        step();
    endtask

    function automatic int shift_at(input int i);
        return (i < shift_q.size()) ? shift_q[i] : -1;
    endfunction

    initial begin
        reset             = 1'b0;
        bus.cs            = 1'b1;
        bus.start         = 1'b0;
        bus.data_bits     = 5'd8;
        bus.parity_en     = 1'b0;
        bus.stop2         = 1'b0;
        bus.break_req     = 1'b0;
        bus.baud_prescale = '0;

        // reset state
        step(); step();
        @(negedge clk);
        chk("rst_busy",  32'(bus.busy),   0);
        chk("rst_txsel", 32'(bus.tx_sel), 0);
        chk("rst_load",  32'(bus.load),   0);
        chk("rst_shift", 32'(bus.shift),  0);
        chk("rst_done",  32'(bus.done),   0);
        step();
        reset = 1'b1;

        // 8N1, prescale 0, start at cycle 10
        tick_to(10);
        clear_stats();
        launch(8, 1'b0, 1'b0, 0);
        wait_done(400, 1'b0);
        chk("8n1_load_cyc", last_load, 11);
        chk("8n1_load_cnt", load_cnt, 1);
        chk("8n1_shift_cnt", shift_cnt, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("8n1_shift%0d", i), shift_at(i), 11 + 31 + 16 * i);
        chk("8n1_done_cyc", last_done, 11 + 159);
        chk("8n1_busy_last", 32'(busy_log[11 + 159]), 1);
        chk("8n1_busy_after", 32'(busy_log[11 + 160]), 0);

        // 7E2, prescale 2; config changed mid-frame must be ignored
        step(); step();
        clear_stats();
        launch(7, 1'b1, 1'b1, 2);
        bus.data_bits = 5'd9;
        bus.parity_en = 1'b0;
        bus.stop2     = 1'b0;
        wait_done(1000, 1'b0);
        chk("7e2_load_cyc", last_load, l);
        chk("7e2_done_cyc", last_done, l + 527);
        chk("7e2_shift_cnt", shift_cnt, 7);
        chk("7e2_shift0", shift_at(0), l + 95);
        for (int k = 0; k < 11; k++) begin
            bad = 0;
            for (int c = l + 48 * k; c < l + 48 * k + 48; c++)
                if (sel_log[c] !== 2'(exp_sel[k])) bad++;
            chk($sformatf("7e2_sel_bit%0d", k), bad, 0);
        end
        bus.baud_prescale = '0;

        // data_bits clamping
        step(); step();
        clear_stats();
        launch(3, 1'b0, 1'b0, 0);
        wait_done(400, 1'b0);
        chk("clamp_lo_shifts", shift_cnt, 5);
        chk("clamp_lo_done", last_done, l + 111);
        step();
        clear_stats();
        launch(20, 1'b0, 1'b0, 0);
        wait_done(400, 1'b0);
        chk("clamp_hi_shifts", shift_cnt, 9);
        chk("clamp_hi_done", last_done, l + 175);

        // cs toggling every cycle, 8N1 prescale 0
        step(); step();
        clear_stats();
        launch(8, 1'b0, 1'b0, 0);
        bus.cs = 1'b0;
        wait_done(800, 1'b1);
        chk("cs_load_cyc", last_load, s + 2);
        chk("cs_done_cyc", last_done, s + 320);
        chk("cs_shift0", shift_at(0), s + 64);
        chk("cs_shift_cnt", shift_cnt, 8);
        chk("cs_load_cnt", load_cnt, 1);

        // break has priority over start
        step(); step();
        clear_stats();
        bus.break_req = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        @(negedge clk);
        chk("brk_txsel", 32'(bus.tx_sel), 1);
        chk("brk_busy", 32'(bus.busy), 1);
        repeat (5) step();
        chk("brk_no_load", load_cnt, 0);
        bus.break_req = 1'b0;
        @(negedge clk);
        chk("brk_hold_busy", 32'(bus.busy), 1);
        step();
        @(negedge clk);
        chk("brk_exit_busy", 32'(bus.busy), 0);
        chk("brk_exit_txsel", 32'(bus.tx_sel), 0);
        chk("brk_no_done", done_cnt, 0);
        step();
        clear_stats();
        launch(8, 1'b0, 1'b0, 0);
        wait_done(400, 1'b0);
        chk("brk_after_len", last_done - last_load, 159);
        chk("brk_after_shifts", shift_cnt, 8);

        // reset during data bit 4
        step(); step();
        clear_stats();
        launch(8, 1'b0, 1'b0, 0);
        tick_to(l + 85);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_txsel", 32'(bus.tx_sel), 0);
        chk("mrst_shifts", shift_cnt, 4);
        repeat (3) step();
        reset = 1'b1;
        repeat (200) step();
        chk("mrst_no_done", done_cnt, 0);
        clear_stats();
        launch(8, 1'b0, 1'b0, 0);
        wait_done(400, 1'b0);
        chk("mrst_load_cyc", last_load, l);
        chk("mrst_len", last_done - last_load, 159);
        chk("mrst_shifts_after", shift_cnt, 8);

        chk("strobe_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
